apb_requester: RTL and testbench
================================

// Module: apb_requester
// PURPOSE
//  APB initiator: the requester end of the APB bus that our APB RAM slaves respond on.
//  - Accepts single read/write commands on a valid/ready command port.
//  - Runs the APB SETUP->ACCESS sequence and waits for pready, with a watchdog timeout.
//  - Returns rdata/error on a valid/ready response port.
//  - Sits between a CPU/test-sequencer front end and one APB slave (no decoding).
// PARAMETERS
//  ADDR_W   32  width of cmd_addr/paddr
//  DATA_W   32  width of wdata/rdata/pwdata/prdata
//  TIMEOUT  16  max ACCESS cycles without pready before abort; 0 = watchdog disabled
// PORTS
//  pclk         in   1       sole clock, rising edge
//  preset       in   1       asynchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       requester can accept (high only in IDLE)
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  transfer address
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       response present; held until rsp_ready
//  rsp_ready    in   1       consumer takes response
//  rsp_rdata    out  DATA_W  read data; 0 for writes, errors, timeouts
//  rsp_err      out  1       pslverr sampled, or timeout
//  rsp_timeout  out  1       transfer aborted by watchdog (implies rsp_err)
//  psel/penable/pwrite  out 1  APB control
//  paddr        out  ADDR_W  APB address
//  pwdata       out  DATA_W  APB write data
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB ready
//  pslverr      in   1       APB slave error
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready (1), state IDLE, watchdog 0.
//  Reset mid-transfer: psel/penable drop immediately; command lost, no response.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; cmd_ready = (state==IDLE), combinational.
//  IDLE
//   - cmd_valid&cmd_ready at edge: latch write/addr/wdata into pwrite/paddr/pwdata.
//   - psel<=1, penable<=0, go to SETUP.
//  SETUP: exactly one cycle; penable<=1, go to ACCESS. pready ignored in SETUP.
//  ACCESS: sample pready at every edge.
//   - pready=1: psel<=0, penable<=0; rsp_err<=pslverr; rsp_timeout<=0.
//     rsp_rdata<=prdata (read, no pslverr), else 0. rsp_valid<=1, go to RESP.
//   - pready=0: watchdog increments.
//   - Watchdog reaches TIMEOUT-1 with pready=0 (TIMEOUT!=0): abort. Drop psel/penable;
//     rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
//   - pready=1 on the abort cycle: normal completion wins.
//  paddr/pwrite/pwdata are stable from SETUP to end of ACCESS; they hold last value afterwards.
//  RESP: rsp_valid held high, data stable. On rsp_ready: rsp_valid<=0, go to IDLE.
//   rsp_ready is ignored outside RESP.
//  Latency (cmd handshake edge = 0, zero-wait slave): SETUP after edge0, ACCESS after edge1,
//   pready sampled edge2, rsp_valid high after edge2. Each wait state adds 1.
//  Min spacing: one IDLE cycle between transfers (psel low >=1 cycle). No pipelining.
//  Watchdog: $clog2(TIMEOUT+1) bits, cleared on entering ACCESS; no wrap (abort first).
//  pslverr is meaningful only with pready=1; otherwise ignored.
// STRUCTURE
//  apb_pkg: typedef enum apb_req_state_t {IDLE,SETUP,ACCESS,RESP};
//   typedef struct apb_rsp_t {rdata, err, timeout}.
//  One sub-module: apb_req_wdog (clear/enable/expired counter, TIMEOUT param).
//  Everything else is one always_ff FSM plus a cmd_ready assign.
// TESTING
//  1. Write 0xDEADBEEF @0x04, zero-wait slave -> psel at +1, penable at +2;
//     rsp_valid after edge2, rsp_err=0.
//  2. Read @0x04 from RAM model, pready after 2 waits -> rsp_rdata=0xDEADBEEF, rsp_valid at edge4.
//  3. Read @0x40, slave returns pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  4. TIMEOUT=4, pready stuck 0 -> abort after 4 ACCESS cycles, psel=0; rsp_err=rsp_timeout=1.
//  5. rsp_ready held low 10 cycles with cmd_valid=1 -> cmd_ready=0 throughout,
//     rsp stable, second cmd accepted only after handshake.
//  6. Assert preset during ACCESS -> psel/penable/rsp_valid=0 same cycle; next cmd completes normally.

Source files
------------

// File: rtl/apb_requester_pkg.sv
// Shared types for the APB requester: FSM state encoding and response payload.
package apb_requester_pkg;

  // Response payload width; the requester's DATA_W is expected to match it.
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_req_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_requester_wdog.sv
// Watchdog for the APB ACCESS phase: counts wait cycles and flags the abort point.
module apb_req_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          WDOG_ON = (TIMEOUT != 0);
  // Abort happens on the ACCESS cycle whose count equals TIMEOUT-1.
  localparam logic [CNT_W-1:0] LAST = WDOG_ON ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] r_cnt;

  assign o_expired_c = WDOG_ON && (r_cnt == LAST);

  // Count ACCESS wait cycles; hold at the abort value instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && WDOG_ON && !o_expired_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB requester: single command in, one SETUP/ACCESS transfer, one response out.
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_req_state_t    r_state;
  apb_rsp_t          r_rsp;
  logic              r_rsp_valid;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic              w_wdog_clr;
  logic              w_wdog_en;
  logic              w_wdog_expired;

  // Watchdog is cleared while in SETUP so it starts from zero in ACCESS.
  assign w_wdog_clr = (r_state == SETUP);
  assign w_wdog_en  = (r_state == ACCESS) && !pready;

  apb_req_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .i_clk      (pclk),
    .i_rst      (preset),
    .i_clr      (w_wdog_clr),
    .i_en       (w_wdog_en),
    .o_expired_c(w_wdog_expired)
  );

  assign cmd_ready   = (r_state == IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = DATA_W'(r_rsp.rdata);
  assign rsp_err     = r_rsp.err;
  assign rsp_timeout = r_rsp.timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;

  // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= IDLE;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_pwrite  <= cmd_write;
            r_paddr   <= cmd_addr;
            r_pwdata  <= cmd_wdata;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // A completing slave wins over a watchdog abort on the same edge.
          if (pready) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp.err     <= pslverr;
            r_rsp.timeout <= 1'b0;
            r_rsp.rdata   <= (!r_pwrite && !pslverr) ? APB_DATA_W'(prdata) : '0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else if (w_wdog_expired) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp.err     <= 1'b1;
            r_rsp.timeout <= 1'b1;
            r_rsp.rdata   <= '0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Randomized bench for apb_requester against a transaction-level reference model.
module tb_apb_requester;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic              pclk;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int n_total = 0;
  int n_bad   = 0;

  // Slave wait-state count for the current transfer; TIMEOUT or more means stuck.
  int slv_waits = 0;

  // Expected memory contents as seen through the requester.
  logic [31:0] ref_mem [16];

  apb_requester #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Addresses with bit 6 set are unmapped on the slave and answer with pslverr.
  function automatic bit is_err_addr(input logic [31:0] addr);
    return addr[6];
  endfunction

  function automatic logic [31:0] mem_init(input int i);
    return 32'(i) * 32'h0101_0101 + 32'h0000_1000;
  endfunction

  // APB RAM slave: pready after slv_waits ACCESS cycles, noise on pready/prdata otherwise.
  initial begin : slave
    logic [31:0] slv_mem [16];
    int k;
    for (int i = 0; i < 16; i++) slv_mem[i] = mem_init(i);
    k = 0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (k == slv_waits) begin
          pready  = 1'b1;
          pslverr = is_err_addr(paddr);
          prdata  = (!pwrite && !pslverr) ? slv_mem[paddr[5:2]] : 32'($urandom);
          if (pwrite && !pslverr) slv_mem[paddr[5:2]] = pwdata;
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = 32'($urandom);
        end
        k++;
      end else begin
        k       = 0;
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = 32'($urandom);
      end
    end
  end

  // One full transfer; called and returns at a falling edge.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input int hold, input bit pend);
    bit          exp_to;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          lat;
    int          idx;
    idx     = int'(addr[5:2]);
    exp_to  = (waits >= int'(TIMEOUT));
    exp_err = exp_to || is_err_addr(addr);
    exp_rd  = (!wr && !exp_err) ? ref_mem[idx] : 32'h0;
    exp_lat = exp_to ? int'(TIMEOUT) + 1 : waits + 2;
    if (wr && !exp_err) ref_mem[idx] = wd;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    slv_waits = waits;
    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);

    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 32'($urandom);
    cmd_wdata = 32'($urandom);
    check_eq("setup_sel_en", 64'({psel, penable}), 64'b10);
    check_eq("setup_addr", 64'(paddr), 64'(addr));
    check_eq("setup_write", 64'(pwrite), 64'(wr));
    check_eq("setup_wdata", 64'(pwdata), 64'(wd));
    check_eq("setup_cmd_ready", 64'(cmd_ready), 64'd0);

    @(negedge pclk);
    check_eq("access_sel_en", 64'({psel, penable}), 64'b11);

    lat = 1;
    while (lat < 40) begin
      @(negedge pclk);
      lat++;
      if (rsp_valid) break;
      check_eq("access_hold", 64'({psel, penable, pwrite, paddr, pwdata}),
               64'({2'b11, wr, addr, wd}));
    end
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("rsp_latency", 64'(lat), 64'(exp_lat));
    check_eq("rsp_bus_idle", 64'({psel, penable}), 64'b00);
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
    check_eq("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));

    for (int i = 0; i < hold; i++) begin
      if (pend && i == 0) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0008;
        cmd_wdata = 32'($urandom);
      end
      @(negedge pclk);
      check_eq("hold_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}),
               64'({1'b1, exp_err, exp_to, exp_rd}));
      check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check_eq("hold_psel", 64'(psel), 64'd0);
    end

    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    check_eq("done_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("done_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("done_psel", 64'(psel), 64'd0);
  endtask

  initial begin : main
    bit          wr;
    bit          e;
    int          idx;
    int          w;
    logic [31:0] addr;

    for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;

    #7;
    check_eq("reset_outputs",
             64'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}),
             64'b1000000);
    check_eq("reset_paddr_rdata", 64'({paddr, rsp_rdata}), 64'd0);
    check_eq("reset_pwdata", 64'(pwdata), 64'd0);

    @(negedge pclk);
    preset = 1'b0;

    // Write then read back through wait states, slave error, watchdog abort.
    do_txn(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_txn(1'b0, 32'h0000_0004, 32'h0, 2, 1, 1'b0);
    do_txn(1'b0, 32'h0000_0040, 32'h0, 1, 0, 1'b0);
    do_txn(1'b1, 32'h0000_000C, 32'h1234_5678, 20, 0, 1'b0);
    do_txn(1'b0, 32'h0000_000C, 32'h0, 3, 0, 1'b0);
    do_txn(1'b0, 32'h0000_000C, 32'h0, 4, 0, 1'b0);

    // Consumer stalls with a new command waiting; it must not be taken early.
    do_txn(1'b0, 32'h0000_0004, 32'h0, 0, 10, 1'b1);
    do_txn(1'b1, 32'h0000_0008, 32'hA5A5_0F0F, 0, 0, 1'b0);

    // Reset in the middle of ACCESS drops the bus at once and loses the command.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0010;
    cmd_wdata = 32'hBAD0_BAD0;
    slv_waits = 10;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check_eq("pre_reset_access", 64'({psel, penable}), 64'b11);
    #2 preset = 1'b1;
    #1;
    check_eq("midreset_bus", 64'({psel, penable, rsp_valid, cmd_ready}), 64'b0001);
    @(negedge pclk);
    preset = 1'b0;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 1, 0, 1'b0);
    do_txn(1'b0, 32'h0000_0008, 32'h0, 0, 2, 1'b0);

    for (int t = 0; t < 80; t++) begin
      wr   = 1'($urandom_range(0, 1));
      idx  = int'($urandom_range(0, 15));
      e    = ($urandom_range(0, 7) == 0);
      addr = {25'h0, e, idx[3:0], 2'b00};
      w    = ($urandom_range(0, 5) < 5) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
      do_txn(wr, addr, 32'($urandom), w, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
